mem_ls_stage: RTL and testbench
===============================

Name: mem_ls_stage

Overview:
- Next-generation MEM stage for the AXI CPU.
- Uses a valid/ready pipeline register in place of the stall vector. Tolerates variable-latency load data through a data_ok handshake, and buffers the result when WB back-pressures.
- Adds LWL/LWR merge and drops any data response that belongs to a flushed load.
- Sits between the EX/DC stage and WB, and generates the exception type consumed by the CP0/ctrl path.

Parameters:
- PAYLOAD_W, 104: opaque pass-through bits carried EX to WB (hilo bus, cp0 bus).
- IRQ_W, 8: interrupt lines compared from cause/status, bits [8+IRQ_W-1:8].

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active low
- flush  in  1  pipeline flush from ctrl
- in_valid  in  1  EX entry valid
- in_ready  out  1  stage can accept
- in_pc  in  32  instruction PC
- in_op  in  7  one-hot {lwr,lwl,lw,lhu,lh,lbu,lb}; all zero = not a load
- in_alu_res  in  32  ALU result / effective address
- in_rt_old  in  32  old rt value for LWL/LWR
- in_we  in  1  register write enable
- in_waddr  in  5  destination register
- in_exc  in  9  {adel_d,ades,eret,ov,tr,ri,bp,sys,adel_if}, bit8..bit0
- in_bad_vaddr  in  32  faulting address
- in_delayslot  in  1  in delay slot
- in_req_sent  in  1  load request was issued to memory
- in_payload  in  PAYLOAD_W  pass-through
- data_ok  in  1  load data return strobe
- rdata  in  32  load data
- cp0_status  in  32  CP0 Status
- cp0_cause  in  32  CP0 Cause
- out_valid  out  1  WB entry valid
- out_ready  in  1  WB accepts
- out_pc, out_we, out_waddr, out_wdata, out_bad_vaddr, out_delayslot, out_payload  out  matching widths
- out_exc_type  out  32  exception code

Behaviour:
- States:
  - IDLE: empty.
  - WAIT: load outstanding.
  - FULL: result held.
  - DRAIN: flushed load still outstanding.
- Reset: resetn=0 at a clk edge sets state IDLE and clears every registered field. All outputs read 0 (out_valid=0, out_exc_type=0). This applies from any state, including WAIT; a response arriving after reset is ignored because the state is IDLE.
- Ready: in_ready = (IDLE) | (FULL & out_ready). It is 0 in WAIT and DRAIN.
- Accept (in_valid & in_ready & ~flush): latch all in_* fields.
  - Next state is WAIT if in_op≠0, in_req_sent=1 and in_exc=0.
  - Otherwise next state is FULL.
- WAIT: on data_ok, latch rdata and go to FULL. out_valid is 1 from the next cycle, so latency is data_ok to out_valid = 1 cycle.
- Non-load: accept at edge N gives out_valid=1 from N+1.
- FULL: out_valid=1 and outputs stay stable until out_ready. Same edge: accept a new entry (FULL or WAIT), else go to IDLE.
- Flush has priority over accept.
  - From WAIT: go to DRAIN.
  - From all other states: go to IDLE, clearing latched fields.
  - In DRAIN: on the first data_ok, drop the data and go to IDLE.
- data_ok in IDLE or FULL is ignored.
- Load result, little-endian, a = alu_res[1:0]:
  - lb/lbu: byte a, sign- or zero-extended.
  - lh/lhu: a=0 gives [15:0], a=2 gives [31:16], extended; a odd gives 0.
  - lw: rdata.
  - lwl: a=0 {rd[7:0],rt[23:0]}; 1 {rd[15:0],rt[15:0]}; 2 {rd[23:0],rt[7:0]}; 3 rd.
  - lwr: a=0 rd; 1 {rt[31:24],rd[31:8]}; 2 {rt[31:16],rd[31:16]}; 3 {rt[31:8],rd[31:24]}.
  - out_wdata = load result for loads, else alu_res.
- Exception logic is combinational on latched fields plus live cp0 inputs. It is evaluated only when out_valid and pc≠0; otherwise out_exc_type=0.
- Exception priority, highest first:
  1. Interrupt ((cause&status)[8+IRQ_W-1:8]≠0 & status[1]=0 & status[0]=1) → 0x01
  2. sys → 0x08
  3. bp → 0x09
  4. ri → 0x0a
  5. tr → 0x0d
  6. ov → 0x0c
  7. eret → 0x0e
  8. ades → 0x05
  9. adel_d → 0x04
  10. adel_if → 0x04
- out_we = latched we & (out_exc_type==0). This is new: an excepting instruction never writes the register file.

Test Plan:
- lb, alu_res=0x1003, rdata=0x80FF1234, data_ok 3 cycles after accept → out_wdata=0xFFFFFF80 with out_valid rising 1 cycle after data_ok; lbu same → 0x00000080.
- lwl a=1, rt=0xAABBCCDD, rdata=0x11223344 → 0x3344CCDD; lwr a=2 → 0xAABB1122.
- Back-pressure: ALU op (alu_res=5, waddr=3) enters FULL, out_ready=0 for 4 cycles → outputs stable and in_ready=0; out_ready=1 with a new in_valid the same cycle → the new entry is accepted with no bubble.
- Flush in WAIT; data_ok 2 cycles later with rdata=0xDEAD → state DRAIN, in_ready=0, data dropped, next data_ok after IDLE not mistaken; out_valid never asserted.
- Interrupt versus syscall: status=0x00000401, cause=0x00000400, in_exc sys=1 → out_exc_type=0x01, out_we=0; with status[0]=0 → 0x08.
- resetn=0 during WAIT → next cycle out_valid=0, state IDLE; a late data_ok is ignored.

Source files
------------

// File: rtl/mem_ls_stage_if.sv
// mem_ls_stage_if: bundles every bus signal of the MEM load/store stage.
//   EX side   : in_valid/in_ready handshake plus the latched instruction fields
//   memory    : data_ok strobe and rdata for returning load data
//   CP0       : live status/cause used for interrupt detection
//   WB side   : out_valid/out_ready handshake plus the result fields
// slave  = the stage's view, master = the surrounding pipeline / bench.
interface mem_ls_stage_if #(
  parameter int PAYLOAD_W = 104
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_pc;
  logic [6:0]           in_op;
  logic [31:0]          in_alu_res;
  logic [31:0]          in_rt_old;
  logic                 in_we;
  logic [4:0]           in_waddr;
  logic [8:0]           in_exc;
  logic [31:0]          in_bad_vaddr;
  logic                 in_delayslot;
  logic                 in_req_sent;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 data_ok;
  logic [31:0]          rdata;
  logic [31:0]          cp0_status;
  logic [31:0]          cp0_cause;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_pc;
  logic                 out_we;
  logic [4:0]           out_waddr;
  logic [31:0]          out_wdata;
  logic [31:0]          out_bad_vaddr;
  logic                 out_delayslot;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [31:0]          out_exc_type;

  modport slave (
    input  in_valid, in_pc, in_op, in_alu_res, in_rt_old, in_we, in_waddr,
           in_exc, in_bad_vaddr, in_delayslot, in_req_sent, in_payload,
           data_ok, rdata, cp0_status, cp0_cause, out_ready,
    output in_ready, out_valid, out_pc, out_we, out_waddr, out_wdata,
           out_bad_vaddr, out_delayslot, out_payload, out_exc_type
  );

  modport master (
    output in_valid, in_pc, in_op, in_alu_res, in_rt_old, in_we, in_waddr,
           in_exc, in_bad_vaddr, in_delayslot, in_req_sent, in_payload,
           data_ok, rdata, cp0_status, cp0_cause, out_ready,
    input  in_ready, out_valid, out_pc, out_we, out_waddr, out_wdata,
           out_bad_vaddr, out_delayslot, out_payload, out_exc_type
  );
endinterface

// File: rtl/mem_ls_stage.sv
// mem_ls_stage: MEM pipeline stage with a single valid/ready entry register.
// Waits for variable-latency load data (data_ok), merges LWL/LWR/sub-word
// loads, holds the result under WB back-pressure and drops data belonging
// to a flushed load. Produces the exception code for CP0/ctrl.
// Ports:
//   clk    : clock
//   resetn : synchronous reset, active low
//   flush  : pipeline flush, overrides accept
//   bus    : mem_ls_stage_if.slave (EX in, memory return, CP0, WB out)
module mem_ls_stage #(
  parameter int PAYLOAD_W = 104,
  parameter int IRQ_W     = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  mem_ls_stage_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, WAIT, FULL, DRAIN} state_t;

  typedef struct packed {
    logic [31:0]          pc;
    logic [6:0]           op;
    logic [31:0]          alu_res;
    logic [31:0]          rt_old;
    logic                 we;
    logic [4:0]           waddr;
    logic [8:0]           exc;
    logic [31:0]          bad_vaddr;
    logic                 delayslot;
    logic [PAYLOAD_W-1:0] payload;
  } ent_t;

  state_t      r_state, w_nstate;
  ent_t        r_ent, w_in;
  logic [31:0] r_rdata;
  logic        w_ready, w_accept, w_ld_wait, w_clear, w_take;
  logic [31:0] w_ld_res, w_exc_type;

  assign w_in = '{pc: bus.in_pc, op: bus.in_op, alu_res: bus.in_alu_res,
                  rt_old: bus.in_rt_old, we: bus.in_we, waddr: bus.in_waddr,
                  exc: bus.in_exc, bad_vaddr: bus.in_bad_vaddr,
                  delayslot: bus.in_delayslot, payload: bus.in_payload};

  assign w_ready   = (r_state == IDLE) | ((r_state == FULL) & bus.out_ready);
  assign w_accept  = bus.in_valid & w_ready & ~flush;
  // Only a clean load that actually went to memory has data to wait for.
  assign w_ld_wait = (|bus.in_op) & bus.in_req_sent & ~(|bus.in_exc);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_ent   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_nstate;
      if (w_clear) begin
        r_ent   <= '0;
        r_rdata <= '0;
      end else if (w_accept) begin
        r_ent   <= w_in;
        r_rdata <= '0;
      end else if (w_take) begin
        r_rdata <= bus.rdata;
      end
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_clear  = 1'b0;
    w_take   = 1'b0;
    case (r_state)
      IDLE: begin
        if (flush)         w_clear  = 1'b1;
        else if (w_accept) w_nstate = w_ld_wait ? WAIT : FULL;
      end
      WAIT: begin
        // The request is still in flight; its response must be swallowed.
        if (flush) w_nstate = DRAIN;
        else if (bus.data_ok) begin
          w_take   = 1'b1;
          w_nstate = FULL;
        end
      end
      FULL: begin
        if (flush) begin
          w_clear  = 1'b1;
          w_nstate = IDLE;
        end else if (bus.out_ready) begin
          w_nstate = w_accept ? (w_ld_wait ? WAIT : FULL) : IDLE;
        end
      end
      DRAIN: begin
        if (flush | bus.data_ok) begin
          w_clear  = 1'b1;
          w_nstate = IDLE;
        end
      end
      default: w_nstate = IDLE;
    endcase
  end

  // Load data alignment / merge, little-endian.
  logic [1:0]  w_a;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_half_ok;
  logic [31:0] w_rd, w_rt;

  assign w_a  = r_ent.alu_res[1:0];
  assign w_rd = r_rdata;
  assign w_rt = r_ent.rt_old;

  always_comb begin
    w_byte    = w_rd[8*w_a +: 8];
    w_half_ok = ~w_a[0];
    w_half    = w_a[1] ? w_rd[31:16] : w_rd[15:0];
    w_ld_res  = '0;
    unique case (1'b1)
      r_ent.op[0]: w_ld_res = {{24{w_byte[7]}}, w_byte};
      r_ent.op[1]: w_ld_res = {24'b0, w_byte};
      r_ent.op[2]: w_ld_res = w_half_ok ? {{16{w_half[15]}}, w_half} : 32'b0;
      r_ent.op[3]: w_ld_res = w_half_ok ? {16'b0, w_half} : 32'b0;
      r_ent.op[4]: w_ld_res = w_rd;
      r_ent.op[5]: begin
        case (w_a)
          2'd0:    w_ld_res = {w_rd[7:0],  w_rt[23:0]};
          2'd1:    w_ld_res = {w_rd[15:0], w_rt[15:0]};
          2'd2:    w_ld_res = {w_rd[23:0], w_rt[7:0]};
          default: w_ld_res = w_rd;
        endcase
      end
      r_ent.op[6]: begin
        case (w_a)
          2'd0:    w_ld_res = w_rd;
          2'd1:    w_ld_res = {w_rt[31:24], w_rd[31:8]};
          2'd2:    w_ld_res = {w_rt[31:16], w_rd[31:16]};
          default: w_ld_res = {w_rt[31:8],  w_rd[31:24]};
        endcase
      end
      default: w_ld_res = '0;
    endcase
  end

  // Exceptions: latched flags plus live CP0 interrupt state.
  logic [31:0] w_pend;
  logic        w_irq, w_out_valid;

  assign w_out_valid = (r_state == FULL);
  assign w_pend      = bus.cp0_cause & bus.cp0_status;
  assign w_irq       = (|w_pend[8+IRQ_W-1:8]) & ~bus.cp0_status[1] & bus.cp0_status[0];

  always_comb begin
    w_exc_type = 32'h0;
    if (w_out_valid && r_ent.pc != 32'h0) begin
      if      (w_irq)        w_exc_type = 32'h01;
      else if (r_ent.exc[1]) w_exc_type = 32'h08;
      else if (r_ent.exc[2]) w_exc_type = 32'h09;
      else if (r_ent.exc[3]) w_exc_type = 32'h0a;
      else if (r_ent.exc[4]) w_exc_type = 32'h0d;
      else if (r_ent.exc[5]) w_exc_type = 32'h0c;
      else if (r_ent.exc[6]) w_exc_type = 32'h0e;
      else if (r_ent.exc[7]) w_exc_type = 32'h05;
      else if (r_ent.exc[8]) w_exc_type = 32'h04;
      else if (r_ent.exc[0]) w_exc_type = 32'h04;
    end
  end

  assign bus.in_ready      = w_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.out_pc        = r_ent.pc;
  assign bus.out_waddr     = r_ent.waddr;
  assign bus.out_wdata     = (|r_ent.op) ? w_ld_res : r_ent.alu_res;
  assign bus.out_bad_vaddr = r_ent.bad_vaddr;
  assign bus.out_delayslot = r_ent.delayslot;
  assign bus.out_payload   = r_ent.payload;
  assign bus.out_exc_type  = w_exc_type;
  // An excepting instruction never commits to the register file.
  assign bus.out_we        = r_ent.we & (w_exc_type == 32'h0);
endmodule

// File: tb/tb_mem_ls_stage.sv
module tb_mem_ls_stage;
  logic clk = 1'b0;
  logic resetn, flush;
  int   n_run = 0, n_fail = 0;

  localparam logic [6:0] OP_LB  = 7'b0000001, OP_LBU = 7'b0000010,
                         OP_LH  = 7'b0000100, OP_LW  = 7'b0010000,
                         OP_LWL = 7'b0100000, OP_LWR = 7'b1000000;

  mem_ls_stage_if #(.PAYLOAD_W(104)) bus ();

  mem_ls_stage #(.PAYLOAD_W(104), .IRQ_W(8)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one entry for a single cycle (caller ensures in_ready=1).
  task automatic send(input logic [6:0] op, input logic [31:0] pc,
                      input logic [31:0] alu, input logic [31:0] rt,
                      input logic [8:0] exc, input logic [4:0] wa);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_pc = pc; bus.in_alu_res = alu;
    bus.in_rt_old = rt; bus.in_exc = exc; bus.in_waddr = wa; bus.in_we = 1'b1;
    bus.in_req_sent = (op != 7'd0);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    #1;
    n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
    n_run++; if (bus.out_exc_type !== 32'h0) begin n_fail++; $display("FAIL reset_exc got %h want 0", bus.out_exc_type); end
    n_run++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b want 1", bus.in_ready); end
    n_run++; if (bus.out_wdata !== 32'h0 || bus.out_pc !== 32'h0 || bus.out_we !== 1'b0)
      begin n_fail++; $display("FAIL reset_fields got wdata=%h pc=%h we=%0b want 0", bus.out_wdata, bus.out_pc, bus.out_we); end
  endtask

  // Byte load with data_ok three cycles after accept.
  task automatic test_byte_load(input logic [6:0] op, input logic [31:0] exp, input string nm);
    bus.out_ready = 1'b0;
    send(op, 32'h100, 32'h1003, 32'h0, 9'h0, 5'd2);
    n_run++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0)
      begin n_fail++; $display("FAIL %s_wait got ready=%0b valid=%0b want 0 0", nm, bus.in_ready, bus.out_valid); end
    tick(); tick();
    bus.data_ok = 1'b1; bus.rdata = 32'h80FF1234;
    #1;
    n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early got valid=%0b want 0", nm, bus.out_valid); end
    tick();
    bus.data_ok = 1'b0; bus.rdata = 32'h0;
    #1;
    n_run++; if (bus.out_valid !== 1'b1 || bus.out_wdata !== exp)
      begin n_fail++; $display("FAIL %s_data got valid=%0b wdata=%h want 1 %h", nm, bus.out_valid, bus.out_wdata, exp); end
    n_run++; if (bus.out_we !== 1'b1 || bus.out_exc_type !== 32'h0)
      begin n_fail++; $display("FAIL %s_we got we=%0b exc=%h want 1 0", nm, bus.out_we, bus.out_exc_type); end
    bus.out_ready = 1'b1;
    tick();
    n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_retire got valid=%0b want 0", nm, bus.out_valid); end
  endtask

  task automatic test_merge(input logic [6:0] op, input logic [31:0] alu,
                            input logic [31:0] rd, input logic [31:0] exp, input string nm);
    bus.out_ready = 1'b0;
    send(op, 32'h200, alu, 32'hAABBCCDD, 9'h0, 5'd7);
    bus.data_ok = 1'b1; bus.rdata = rd;
    tick();
    bus.data_ok = 1'b0;
    n_run++; if (bus.out_valid !== 1'b1 || bus.out_wdata !== exp)
      begin n_fail++; $display("FAIL %s got valid=%0b wdata=%h want 1 %h", nm, bus.out_valid, bus.out_wdata, exp); end
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_pressure();
    bus.out_ready = 1'b0;
    send(7'd0, 32'h300, 32'd5, 32'h0, 9'h0, 5'd3);
    n_run++; if (bus.out_valid !== 1'b1 || bus.out_wdata !== 32'd5 || bus.out_waddr !== 5'd3)
      begin n_fail++; $display("FAIL bp_first got valid=%0b wdata=%h waddr=%0d want 1 5 3", bus.out_valid, bus.out_wdata, bus.out_waddr); end
    bus.in_valid = 1'b1; bus.in_alu_res = 32'd9; bus.in_waddr = 5'd4; bus.in_pc = 32'h304;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_run++; if (bus.out_valid !== 1'b1 || bus.out_wdata !== 32'd5 || bus.out_waddr !== 5'd3 || bus.in_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold%0d got valid=%0b wdata=%h waddr=%0d ready=%0b want 1 5 3 0", i, bus.out_valid, bus.out_wdata, bus.out_waddr, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    #1;
    n_run++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready got %0b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_run++; if (bus.out_valid !== 1'b1 || bus.out_wdata !== 32'd9 || bus.out_waddr !== 5'd4)
      begin n_fail++; $display("FAIL bp_next got valid=%0b wdata=%h waddr=%0d want 1 9 4", bus.out_valid, bus.out_wdata, bus.out_waddr); end
    tick();
    n_run++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_flush_wait();
    int seen = 0;
    bus.out_ready = 1'b1;
    send(OP_LW, 32'h400, 32'h2000, 32'h0, 9'h0, 5'd5);
    if (bus.out_valid) seen++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    if (bus.out_valid) seen++;
    n_run++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_drain_ready got %0b want 0", bus.in_ready); end
    tick();
    if (bus.out_valid) seen++;
    bus.data_ok = 1'b1; bus.rdata = 32'hDEAD;
    tick();
    bus.data_ok = 1'b0;
    if (bus.out_valid) seen++;
    n_run++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle_ready got %0b want 1", bus.in_ready); end
    bus.data_ok = 1'b1; bus.rdata = 32'hBEEF;
    tick();
    bus.data_ok = 1'b0;
    if (bus.out_valid) seen++;
    tick();
    if (bus.out_valid) seen++;
    n_run++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_valid got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_irq();
    bus.out_ready = 1'b0;
    bus.cp0_status = 32'h00000401; bus.cp0_cause = 32'h00000400;
    send(7'd0, 32'h500, 32'h1, 32'h0, 9'h002, 5'd6);
    n_run++; if (bus.out_exc_type !== 32'h01 || bus.out_we !== 1'b0)
      begin n_fail++; $display("FAIL irq got exc=%h we=%0b want 01 0", bus.out_exc_type, bus.out_we); end
    bus.cp0_status = 32'h00000400;
    #1;
    n_run++; if (bus.out_exc_type !== 32'h08 || bus.out_we !== 1'b0)
      begin n_fail++; $display("FAIL sys got exc=%h we=%0b want 08 0", bus.out_exc_type, bus.out_we); end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_exc = 9'h00C; bus.in_pc = 32'h504;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    n_run++; if (bus.out_exc_type !== 32'h09) begin n_fail++; $display("FAIL bp_over_ri got exc=%h want 09", bus.out_exc_type); end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_exc = 9'h130; bus.in_pc = 32'h508;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    n_run++; if (bus.out_exc_type !== 32'h0d) begin n_fail++; $display("FAIL tr_over_ov got exc=%h want 0d", bus.out_exc_type); end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_exc = 9'h002; bus.in_pc = 32'h0;
    tick();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    n_run++; if (bus.out_exc_type !== 32'h0 || bus.out_we !== 1'b1)
      begin n_fail++; $display("FAIL pc0 got exc=%h we=%0b want 0 1", bus.out_exc_type, bus.out_we); end
    bus.out_ready = 1'b1; bus.in_exc = 9'h0;
    bus.cp0_status = 32'h0; bus.cp0_cause = 32'h0;
    tick();
  endtask

  task automatic test_reset_wait();
    bus.out_ready = 1'b0;
    send(OP_LW, 32'h600, 32'h3000, 32'h0, 9'h0, 5'd8);
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    n_run++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      begin n_fail++; $display("FAIL rstwait got valid=%0b ready=%0b want 0 1", bus.out_valid, bus.in_ready); end
    bus.data_ok = 1'b1; bus.rdata = 32'h12345678;
    tick();
    bus.data_ok = 1'b0;
    n_run++; if (bus.out_valid !== 1'b0 || bus.out_wdata !== 32'h0)
      begin n_fail++; $display("FAIL rstwait_late got valid=%0b wdata=%h want 0 0", bus.out_valid, bus.out_wdata); end
    bus.out_ready = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_op = '0; bus.in_alu_res = '0;
    bus.in_rt_old = '0; bus.in_we = 1'b0; bus.in_waddr = '0; bus.in_exc = '0;
    bus.in_bad_vaddr = '0; bus.in_delayslot = 1'b0; bus.in_req_sent = 1'b0;
    bus.in_payload = '0; bus.data_ok = 1'b0; bus.rdata = '0;
    bus.cp0_status = '0; bus.cp0_cause = '0; bus.out_ready = 1'b1;
    test_reset();
    test_byte_load(OP_LB,  32'hFFFFFF80, "lb");
    test_byte_load(OP_LBU, 32'h00000080, "lbu");
    test_merge(OP_LWL, 32'h2001, 32'h11223344, 32'h3344CCDD, "lwl_a1");
    test_merge(OP_LWR, 32'h2002, 32'h11223344, 32'hAABB1122, "lwr_a2");
    test_merge(OP_LH,  32'h2003, 32'h11223344, 32'h00000000, "lh_odd");
    test_merge(OP_LH,  32'h2002, 32'h8001FFFF, 32'hFFFF8001, "lh_a2");
    test_back_pressure();
    test_flush_wait();
    test_irq();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
